ins_loader: RTL and testbench
=============================

// Module: ins_loader
// PURPOSE
//  Program loader: the write side of the instruction memory. Takes a byte stream over a valid/ready
//  handshake, packs bytes big-endian into 32-bit instructions and drives the instruction-memory write
//  port (wrEn/wrAddress/wrIns). Holds the CPU in reset until the load completes. Sits between the
//  host/boot link and insMemory.
// PARAMETERS
//  ADDR_W  10  instruction address width, in words; DEPTH = 2**ADDR_W = 1024
//  WORD_W  32  instruction width; bytes per word = WORD_W/8 = 4 (localparam)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active high
//  start      in   1       1-cycle pulse: begin a new load
//  byteValid  in   1       byteData is valid
//  byteData   in   8       stream byte
//  byteReady  out  1       loader accepts a byte; transfer = byteValid & byteReady
//  wrEn       out  1       instruction-memory write strobe, 1 cycle per word
//  wrAddress  out  ADDR_W  word address for the write
//  wrIns      out  WORD_W  instruction word for the write
//  loadDone   out  1       load finished OK; sticky until the next start
//  loadErr    out  1       header count > DEPTH; sticky until the next start
//  cpuHold    out  1       high = CPU held in reset
// BEHAVIOUR
//  Reset: state=IDLE; byteReady=0, wrEn=0, wrAddress=0, wrIns=0, loadDone=0, loadErr=0, cpuHold=1.
//  Stream format: 2-byte word count N, MSB first. Then N words of 4 bytes each, MSB first
//  (byte0 -> wrIns[31:24]).
//  FSM states: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
//   IDLE   : byteReady=0. start -> HDR_HI, clear loadDone/loadErr, cpuHold=1, word index=0.
//   HDR_HI : byteReady=1. On transfer, N[15:8] <= byte -> HDR_LO.
//   HDR_LO : byteReady=1. On transfer, N[7:0] <= byte; then
//            N==0 -> DONE; N>DEPTH -> ERROR; else -> DATA with byte count=0.
//   DATA   : byteReady=1. Each transfer shifts the byte into the word. The 4th transfer -> WRITE.
//   WRITE  : byteReady=0 for exactly 1 cycle. wrEn=1, wrAddress=index, wrIns=assembled word.
//            Then index+1; if index+1==N -> DONE, else -> DATA.
//   DONE   : loadDone=1, cpuHold=0, byteReady=0. start -> HDR_HI (new load, cpuHold back to 1).
//   ERROR  : loadErr=1, cpuHold=1, byteReady=0, no writes. start -> HDR_HI.
//  Latency: wrEn rises on the cycle after the clock edge that accepts the 4th byte of a word.
//  Sustained throughput: 1 word per 5 cycles.
//  wrEn is low in every state except WRITE. wrAddress/wrIns hold their last value when wrEn=0.
//  start in HDR_HI/HDR_LO/DATA/WRITE is ignored (no restart mid-load).
//  Bytes that arrive with byteReady=0 are not consumed. The sender must hold byteValid/byteData.
//  N==DEPTH (1024) is legal: last write at wrAddress=1023. Index counter is ADDR_W+1 bits, no wrap.
//  Async rst mid-load: every output returns to its reset value immediately, with no partial write.
//  Already-written words are not undone.
//  Counts: N is 16 bits unsigned, byte counter is 2 bits, comparisons are unsigned.
// STRUCTURE
//  Shared package holds: state encoding localparams, BYTES_PER_WORD, HDR_BYTES=2.
//  One natural sub-module: byte_packer, a 4-byte shift register plus 2-bit count.
//  It asserts wordFull on the 4th byte. The FSM and counters stay in ins_loader.
//  The testbench instantiates ins_loader driving insMemory's write-capable variant.
//  Readback goes through rdAddress/rdIns.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs at reset values asynchronously; cpuHold=1, byteReady=0.
//  2 Basic load: start, bytes 00 02 | 20 08 00 05 | AC 08 00 04 ->
//    wrEn@addr0=0x20080005, wrEn@addr1=0xAC080004. Then loadDone=1, cpuHold=0.
//    Readback matches.
//  3 Backpressure/gaps: same stream with byteValid low for random 0-3 cycles between bytes ->
//    identical writes. No byte consumed while byteReady=0 (the WRITE cycle).
//  4 Boundaries: N=0 (00 00) -> DONE, no wrEn.
//    N=1024 -> last write wrAddress=1023, then DONE.
//    N=1025 (04 01) -> ERROR, loadErr=1, cpuHold=1, no wrEn.
//  5 Ignored/restart: start pulsed during DATA -> no effect, load completes.
//    start in DONE -> new load, loadDone clears the cycle after, cpuHold=1.
//  6 Reset mid-load: rst after 1st word's 2nd byte -> outputs reset.
//    A new full load afterwards writes from addr 0 correctly.

Source files
------------

// File: rtl/ins_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and stream framing constants.
package ins_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/ins_loader_byte_packer.sv
// Big-endian byte packer: keeps the first three bytes of a word and presents the
// full word combinationally together with the fourth byte, flagging wordFull.
module byte_packer
    import ins_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_full
);

    logic [WORD_W-9:0] r_bytes;
    logic [1:0]        r_count;

    // Shift accepted bytes in MSB-first; the count wraps naturally after the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bytes <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else if (i_shift) begin
            r_bytes <= {r_bytes[WORD_W-17:0], i_byte};
            r_count <= r_count + 2'd1;
        end
    end

    // The assembled word includes the byte being accepted this cycle.
    always_comb begin
        o_word      = {r_bytes, i_byte};
        o_word_full = i_shift && (r_count == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/ins_loader.sv
// Program loader: parses a counted byte stream, writes packed words into the
// instruction memory and holds the CPU in reset until the load completes.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | after reset, waiting for start, CPU held
//  HDR_HI   | waiting for word count high byte
//  HDR_LO   | waiting for word count low byte, then range check
//  DATA     | collecting the 4 bytes of the current word
//  WRITE    | one-cycle write strobe, no byte accepted
//  DONE     | load complete, CPU released, waiting for a new start
//  ERROR    | count too large, CPU held, waiting for a new start
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byteValid,
    input  logic [7:0]        byteData,
    output logic              byteReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddress,
    output logic [WORD_W-1:0] wrIns,
    output logic              loadDone,
    output logic              loadErr,
    output logic              cpuHold
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_count_n;
    logic [ADDR_W:0]   r_index;
    logic [ADDR_W-1:0] r_wr_address;
    logic [WORD_W-1:0] r_wr_ins;

    logic              w_restart;
    logic              w_pk_shift;
    logic [WORD_W-1:0] w_word;
    logic              w_word_full;
    logic [15:0]       w_n_full;
    logic [ADDR_W:0]   w_index_inc;
    logic              w_last;

    assign w_n_full    = {r_count_n[15:8], byteData};
    assign w_index_inc = r_index + 1'b1;
    assign w_last      = (16'(w_index_inc) == r_count_n);
    assign wrAddress   = r_wr_address;
    assign wrIns       = r_wr_ins;

    byte_packer #(.WORD_W(WORD_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_restart),
        .i_shift    (w_pk_shift),
        .i_byte     (byteData),
        .o_word     (w_word),
        .o_word_full(w_word_full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; status flags follow the state so reset clears them at once.
    always_comb begin
        w_next     = r_state;
        byteReady  = 1'b0;
        wrEn       = 1'b0;
        loadDone   = 1'b0;
        loadErr    = 1'b0;
        cpuHold    = 1'b1;
        w_pk_shift = 1'b0;
        w_restart  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_restart = 1'b1;
                    w_next    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                byteReady = 1'b1;
                if (byteValid) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                byteReady = 1'b1;
                if (byteValid) begin
                    if (w_n_full == 16'd0)             w_next = S_DONE;
                    else if (w_n_full > 16'(DEPTH))    w_next = S_ERROR;
                    else                               w_next = S_DATA;
                end
            end
            S_DATA: begin
                byteReady  = 1'b1;
                w_pk_shift = byteValid;
                if (w_word_full) w_next = S_WRITE;
            end
            S_WRITE: begin
                wrEn   = 1'b1;
                w_next = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                loadDone = 1'b1;
                cpuHold  = 1'b0;
                if (start) begin
                    w_restart = 1'b1;
                    w_next    = S_HDR_HI;
                end
            end
            S_ERROR: begin
                loadErr = 1'b1;
                if (start) begin
                    w_restart = 1'b1;
                    w_next    = S_HDR_HI;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Header capture, word index and write-port registers (held between writes).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_n    <= 16'd0;
            r_index      <= '0;
            r_wr_address <= '0;
            r_wr_ins     <= '0;
        end else begin
            if (w_restart) r_index <= '0;
            if (r_state == S_HDR_HI && byteValid) r_count_n[15:8] <= byteData;
            if (r_state == S_HDR_LO && byteValid) r_count_n[7:0]  <= byteData;
            if (w_word_full) begin
                r_wr_address <= r_index[ADDR_W-1:0];
                r_wr_ins     <= w_word;
            end
            if (r_state == S_WRITE) r_index <= w_index_inc;
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: stimulus pushes expected writes, a monitor
// pops and compares on every wrEn, and a small memory model provides readback.
module tb_ins_loader;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byteValid = 1'b0;
    logic [7:0]  byteData = 8'h00;
    logic        byteReady;
    logic        wrEn;
    logic [9:0]  wrAddress;
    logic [31:0] wrIns;
    logic        loadDone;
    logic        loadErr;
    logic        cpuHold;

    logic [31:0] mem [0:1023];
    logic [9:0]  rdAddress = 10'd0;
    logic [31:0] rdIns;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    wr_t exp_q[$];

    assign rdIns = mem[rdAddress];

    always #5 clk = ~clk;

    ins_loader #(.ADDR_W(10), .WORD_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .byteValid(byteValid),
        .byteData (byteData),
        .byteReady(byteReady),
        .wrEn     (wrEn),
        .wrAddress(wrAddress),
        .wrIns    (wrIns),
        .loadDone (loadDone),
        .loadErr  (loadErr),
        .cpuHold  (cpuHold)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is checked against the scoreboard and stored in the memory model.
    always @(negedge clk) begin
        if (!rst && wrEn) begin
            n_writes++;
            chk("ready_low_in_write", 32'(byteReady), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", wrAddress, wrIns);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wrAddress), 32'(e.a));
                chk("wr_ins", wrIns, e.d);
            end
            mem[wrAddress] = wrIns;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byteValid = 1'b1;
        byteData  = b;
        for (int t = 0; t < 50; t++) begin
            if (byteReady) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        byteValid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept_timeout: byte %h not accepted, required acceptance within 50 cycles", b);
        end
    endtask

    task automatic send_gap(input logic [7:0] b, input int gapmax);
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        send_byte(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            if (loadDone || loadErr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL end_timeout: loadDone/loadErr still low, required high within 20000 cycles");
        end
    endtask

    task automatic do_load(input logic [31:0] words[$], input int gapmax);
        int n;
        n = words.size();
        pulse_start();
        for (int i = 0; i < n; i++) exp_q.push_back('{a: 10'(i), d: words[i]});
        send_gap(8'(n >> 8), gapmax);
        send_gap(8'(n), gapmax);
        for (int i = 0; i < n; i++) begin
            send_gap(words[i][31:24], gapmax);
            send_gap(words[i][23:16], gapmax);
            send_gap(words[i][15:8],  gapmax);
            send_gap(words[i][7:0],   gapmax);
        end
        wait_end();
    endtask

    task automatic readback(input int addr, input logic [31:0] exp, input string name);
        rdAddress = 10'(addr);
        #1;
        chk(name, rdIns, exp);
    endtask

    initial begin
        logic [31:0] w[$];
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // reset values
        #13;
        chk("rst_byteReady", 32'(byteReady), 32'd0);
        chk("rst_wrEn",      32'(wrEn),      32'd0);
        chk("rst_wrAddress", 32'(wrAddress), 32'd0);
        chk("rst_wrIns",     wrIns,          32'd0);
        chk("rst_loadDone",  32'(loadDone),  32'd0);
        chk("rst_loadErr",   32'(loadErr),   32'd0);
        chk("rst_cpuHold",   32'(cpuHold),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_byteReady", 32'(byteReady), 32'd0);

        // basic two-word load
        w = '{32'h20080005, 32'hAC080004};
        do_load(w, 0);
        chk("basic_loadDone", 32'(loadDone), 32'd1);
        chk("basic_cpuHold",  32'(cpuHold),  32'd0);
        chk("basic_loadErr",  32'(loadErr),  32'd0);
        chk("basic_nwrites",  32'(n_writes), 32'd2);
        readback(0, 32'h20080005, "basic_rd0");
        readback(1, 32'hAC080004, "basic_rd1");

        // same stream with random gaps
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        do_load(w, 3);
        chk("gap_loadDone", 32'(loadDone), 32'd1);
        chk("gap_nwrites",  32'(n_writes), 32'd4);
        readback(0, 32'h20080005, "gap_rd0");
        readback(1, 32'hAC080004, "gap_rd1");

        // N = 0
        w = {};
        base = n_writes;
        do_load(w, 0);
        repeat (3) @(negedge clk);
        chk("n0_loadDone", 32'(loadDone), 32'd1);
        chk("n0_cpuHold",  32'(cpuHold),  32'd0);
        chk("n0_nwrites",  32'(n_writes), 32'(base));

        // N = DEPTH
        w = {};
        for (int i = 0; i < 1024; i++) w.push_back({16'(i), 16'hBEEF ^ 16'(i)});
        base = n_writes;
        do_load(w, 0);
        chk("full_loadDone",  32'(loadDone),  32'd1);
        chk("full_nwrites",   32'(n_writes),  32'(base + 1024));
        chk("full_last_addr", 32'(wrAddress), 32'd1023);
        readback(1023, {16'd1023, 16'hBEEF ^ 16'd1023}, "full_rd1023");
        readback(512,  {16'd512,  16'hBEEF ^ 16'd512},  "full_rd512");

        // N = DEPTH + 1
        base = n_writes;
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        wait_end();
        repeat (5) @(negedge clk);
        chk("err_loadErr",   32'(loadErr),   32'd1);
        chk("err_loadDone",  32'(loadDone),  32'd0);
        chk("err_cpuHold",   32'(cpuHold),   32'd1);
        chk("err_byteReady", 32'(byteReady), 32'd0);
        chk("err_nwrites",   32'(n_writes),  32'(base));

        // start during DATA is ignored
        pulse_start();
        chk("restart_err_clear", 32'(loadErr), 32'd0);
        exp_q.push_back('{a: 10'd0, d: 32'h12345678});
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_start();
        send_byte(8'h56);
        send_byte(8'h78);
        wait_end();
        chk("ign_loadDone", 32'(loadDone), 32'd1);
        readback(0, 32'h12345678, "ign_rd0");

        // start in DONE begins a new load
        pulse_start();
        chk("redo_loadDone",  32'(loadDone),  32'd0);
        chk("redo_cpuHold",   32'(cpuHold),   32'd1);
        chk("redo_byteReady", 32'(byteReady), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_end();
        chk("redo_done", 32'(loadDone), 32'd1);

        // async reset in the middle of a word
        base = n_writes;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_byteReady", 32'(byteReady), 32'd0);
        chk("mid_rst_wrEn",      32'(wrEn),      32'd0);
        chk("mid_rst_wrAddress", 32'(wrAddress), 32'd0);
        chk("mid_rst_wrIns",     wrIns,          32'd0);
        chk("mid_rst_loadDone",  32'(loadDone),  32'd0);
        chk("mid_rst_loadErr",   32'(loadErr),   32'd0);
        chk("mid_rst_cpuHold",   32'(cpuHold),   32'd1);
        @(negedge clk);
        chk("mid_rst_nwrites", 32'(n_writes), 32'(base));
        rst = 1'b0;
        @(negedge clk);
        w = '{32'hCAFEBABE, 32'h01020304, 32'hA0B0C0D0};
        do_load(w, 2);
        chk("post_rst_loadDone", 32'(loadDone), 32'd1);
        chk("post_rst_nwrites",  32'(n_writes), 32'(base + 3));
        readback(0, 32'hCAFEBABE, "post_rst_rd0");
        readback(1, 32'h01020304, "post_rst_rd1");
        readback(2, 32'hA0B0C0D0, "post_rst_rd2");

        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
